// File: rtl/super_res_fetch_fifo.sv
// Prefetch stage between the SDRAM read port and the super-res pixel renderer.
// Streams 32-bit VRAM words from a page start address into a show-ahead FIFO,
// issuing reads only inside the bus window, with credit-based flow control
// (FIFO occupancy + outstanding reads never exceed DEPTH).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no requests issued; FIFO contents remain poppable
// FETCH | issuing reads while window, credit and remaining allow
// DRAIN | discarding in-flight returns after a flush
module super_res_fetch_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_i,
    input  logic        frame_start_i,
    input  logic [17:0] start_addr_i,
    input  logic [17:0] frame_words_i,
    input  logic        bus_window_i,
    output logic        mem_req_o,
    output logic [17:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        pop_i,
    output logic [31:0] data_out_o,
    output logic        data_valid_o,
    output logic        underflow_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CRW = CW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic [17:0]     mem_addr_q, mem_addr_d;
    logic [17:0]     pend_addr_q, pend_addr_d;
    logic            stale_q, stale_d;
    logic [17:0]     remaining_q, remaining_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     data_out_q, data_out_d;
    logic            underflow_q, underflow_d;
    logic [31:0]     fifo_mem [DEPTH];
    logic [CRW-1:0]  credit;

    logic restart, flush, hs, hold, push, pop_ok, busy;

    // A request held at flush time still completes; it is marked stale so it
    // neither consumes the new frame's word budget nor feeds the FIFO.
    assign restart = enable_i & frame_start_i;
    assign flush   = restart | ~enable_i;
    assign hs      = mem_req_q & mem_ack_i;
    assign hold    = mem_req_q & ~mem_ack_i;
    assign push    = mem_rvalid_i & (state_q != DRAIN) & ~flush;
    assign pop_ok  = pop_i & (count_q != '0) & ~flush;
    assign busy    = (outstanding_d != '0) | hold;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state selection; flush conditions override the per-state rules.
    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = busy ? DRAIN : IDLE;
        end else if (frame_start_i) begin
            state_d = busy ? DRAIN : FETCH;
        end else begin
            unique case (state_q)
                FETCH:   if (remaining_d == '0 && !busy) state_d = IDLE;
                DRAIN:   if (!busy) state_d = FETCH;
                default: state_d = state_q;
            endcase
        end
    end

    // Counters, pointers, address and FIFO head next values.
    always_comb begin
        outstanding_d = outstanding_q + CW'(hs) - CW'(mem_rvalid_i);
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop_ok);
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        end

        remaining_d = remaining_q;
        if (!enable_i)            remaining_d = '0;
        else if (restart)         remaining_d = frame_words_i;
        else if (hs && !stale_q)  remaining_d = remaining_q - 18'd1;

        pend_addr_d = restart ? start_addr_i : pend_addr_q;

        mem_addr_d = mem_addr_q;
        if (hs) begin
            if (restart)      mem_addr_d = start_addr_i;
            else if (stale_q) mem_addr_d = pend_addr_q;
            else              mem_addr_d = mem_addr_q + 18'd1;
        end else if (restart && !mem_req_q) begin
            mem_addr_d = start_addr_i;
        end

        stale_d = hs ? 1'b0 : (stale_q | (flush & mem_req_q));

        underflow_d = restart ? 1'b0 : (underflow_q | (pop_i & (count_q == '0)));

        data_out_d = data_out_q;
        if (push && (count_q == '0 || (count_q == CW'(1) && pop_ok)))
            data_out_d = mem_rdata_i;
        else if (pop_ok && count_q > CW'(1))
            data_out_d = fifo_mem[rd_ptr_q + AW'(1)];
    end

    // Request output: keep a pending request, otherwise issue on window and credit.
    always_comb begin
        credit    = {1'b0, count_d} + {1'b0, outstanding_d};
        mem_req_d = 1'b0;
        if (hold)
            mem_req_d = 1'b1;
        else if (state_d == FETCH && bus_window_i && remaining_d != '0 &&
                 credit < CRW'(DEPTH))
            mem_req_d = 1'b1;
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            pend_addr_q   <= '0;
            stale_q       <= 1'b0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            data_out_q    <= '0;
            underflow_q   <= 1'b0;
        end else begin
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            pend_addr_q   <= pend_addr_d;
            stale_q       <= stale_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            data_out_q    <= data_out_d;
            underflow_q   <= underflow_d;
        end
    end

    // FIFO storage write; no reset needed, validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= mem_rdata_i;
    end

`ifndef SYNTHESIS
    // Credit accounting must make a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!reset)
            assert (!(push && !pop_ok && count_q == CW'(DEPTH)))
                else $error("fifo overflow");
    end
`endif

    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign data_out_o   = data_out_q;
    assign data_valid_o = (count_q != '0);
    assign underflow_o  = underflow_q;

endmodule

// File: tb/tb_super_res_fetch_fifo.sv
// Bench for super_res_fetch_fifo: table of frames with hand-computed request
// addresses and popped words, plus directed multi-cycle sequences.
module tb_super_res_fetch_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        frame_start = 1'b0;
    logic [17:0] start_addr = '0;
    logic [17:0] frame_words = '0;
    logic        bus_window = 1'b0;
    logic        mem_req;
    logic [17:0] mem_addr;
    logic        mem_ack = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        pop = 1'b0;
    logic [31:0] data_out;
    logic        data_valid;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    super_res_fetch_fifo #(.DEPTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (enable),
        .frame_start_i(frame_start),
        .start_addr_i (start_addr),
        .frame_words_i(frame_words),
        .bus_window_i (bus_window),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_ack_i    (mem_ack),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .pop_i        (pop),
        .data_out_o   (data_out),
        .data_valid_o (data_valid),
        .underflow_o  (underflow)
    );

    always #5 clk = ~clk;

    // Memory model: returns rdata=addr two cycles after each handshake,
    // in order; hold_ret lets reads pile up as outstanding.
    logic [17:0] pq_addr[$];
    int          pq_due[$];
    logic [17:0] log_addr[$];
    int          log_cyc[$];
    int          cyc = 0;
    logic        hold_ret = 1'b0;

    always @(negedge clk) begin
        cyc++;
        mem_rvalid = 1'b0;
        if (reset) begin
            pq_addr.delete();
            pq_due.delete();
        end else begin
            if (!hold_ret && pq_addr.size() > 0 && pq_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = {14'h0, pq_addr[0]};
                void'(pq_addr.pop_front());
                void'(pq_due.pop_front());
            end
            if (mem_req && mem_ack) begin
                pq_addr.push_back(mem_addr);
                pq_due.push_back(cyc + 2);
                log_addr.push_back(mem_addr);
                log_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    typedef struct {
        logic [17:0]      start;
        logic [17:0]      words;
        int               n;
        logic [3:0][17:0] exp;
    } vec_t;

    vec_t vecs[4];
    int   base;

    initial begin
        vecs[0] = '{18'h00100, 18'd4, 4, {18'h00103, 18'h00102, 18'h00101, 18'h00100}};
        vecs[1] = '{18'h3FFFE, 18'd3, 3, {18'h00000, 18'h00000, 18'h3FFFF, 18'h3FFFE}};
        vecs[2] = '{18'h12345, 18'd0, 0, {18'h00000, 18'h00000, 18'h00000, 18'h00000}};
        vecs[3] = '{18'h2ABCD, 18'd1, 1, {18'h00000, 18'h00000, 18'h00000, 18'h2ABCD}};

        // Reset values
        run(2);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_dout", data_out, 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_uflow", 32'(underflow), 32'd0);
        reset = 1'b0;
        enable = 1'b1;
        bus_window = 1'b1;
        run(2);

        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            base = log_addr.size();
            start_addr  = vecs[v].start;
            frame_words = vecs[v].words;
            pulse_fs();
            chk("first_req", 32'(mem_req), 32'(vecs[v].n != 0));
            chk("first_addr", 32'(mem_addr), 32'(vecs[v].start));
            run(15);
            chk("req_count", log_addr.size() - base, vecs[v].n);
            for (int i = 0; i < vecs[v].n; i++) begin
                chk("req_addr", 32'(log_addr[base + i]), 32'(vecs[v].exp[i]));
                if (i > 0) chk("b2b", log_cyc[base + i] - log_cyc[base + i - 1], 1);
            end
            chk("req_idle", 32'(mem_req), 32'd0);
            chk("valid", 32'(data_valid), 32'(vecs[v].n != 0));
            for (int i = 0; i < vecs[v].n; i++) begin
                chk("pop_data", data_out, 32'(vecs[v].exp[i]));
                pop = 1'b1;
                step();
                pop = 1'b0;
            end
            chk("empty", 32'(data_valid), 32'd0);
            chk("no_uflow", 32'(underflow), 32'd0);
        end

        // Underflow is sticky until the next frame_start
        pop = 1'b1;
        step();
        pop = 1'b0;
        chk("uflow_set", 32'(underflow), 32'd1);
        chk("uflow_dout", data_out, 32'h2ABCD);
        run(3);
        chk("uflow_hold", 32'(underflow), 32'd1);
        frame_words = 18'd0;
        pulse_fs();
        chk("uflow_clr", 32'(underflow), 32'd0);

        // Backpressure: 20 words, no pops
        base = log_addr.size();
        start_addr  = 18'h00400;
        frame_words = 18'd20;
        pulse_fs();
        run(30);
        chk("bp_count", log_addr.size() - base, 8);
        chk("bp_req", 32'(mem_req), 32'd0);
        chk("bp_head", data_out, 32'h400);
        pop = 1'b1;
        step();
        pop = 1'b0;
        run(10);
        chk("bp_one_more", log_addr.size() - base, 9);
        chk("bp_addr9", 32'(log_addr[log_addr.size() - 1]), 32'h408);
        chk("bp_req2", 32'(mem_req), 32'd0);
        chk("bp_head2", data_out, 32'h401);
        enable = 1'b0;
        run(3);
        chk("dis_flush", 32'(data_valid), 32'd0);
        enable = 1'b1;
        step();

        // Bus window closed before any request
        base = log_addr.size();
        bus_window  = 1'b0;
        start_addr  = 18'h00800;
        frame_words = 18'd4;
        pulse_fs();
        run(10);
        chk("bw_none", log_addr.size() - base, 0);
        chk("bw_req0", 32'(mem_req), 32'd0);
        // Window drops while a request waits for ack
        mem_ack = 1'b0;
        bus_window = 1'b1;
        step();
        chk("bw_rise", 32'(mem_req), 32'd1);
        chk("bw_rise_addr", 32'(mem_addr), 32'h800);
        bus_window = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bw_hold_req", 32'(mem_req), 32'd1);
            chk("bw_hold_addr", 32'(mem_addr), 32'h800);
        end
        mem_ack = 1'b1;
        step();
        chk("bw_done", log_addr.size() - base, 1);
        chk("bw_drop", 32'(mem_req), 32'd0);
        run(5);
        chk("bw_wait", log_addr.size() - base, 1);
        bus_window = 1'b1;
        run(10);
        chk("bw_resume", log_addr.size() - base, 4);
        chk("bw_last", 32'(log_addr[log_addr.size() - 1]), 32'h803);
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();

        // Mid-flight restart with three reads outstanding
        base = log_addr.size();
        hold_ret    = 1'b1;
        start_addr  = 18'h00200;
        frame_words = 18'd3;
        pulse_fs();
        run(6);
        chk("mf_issued", log_addr.size() - base, 3);
        start_addr  = 18'h20000;
        frame_words = 18'd2;
        pulse_fs();
        hold_ret = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mf_nodata", 32'(data_valid), 32'd0);
            if (i < 2) chk("mf_noreq", 32'(mem_req), 32'd0);
            step();
        end
        chk("mf_nodata2", 32'(data_valid), 32'd0);
        run(10);
        chk("mf_count", log_addr.size() - base, 5);
        chk("mf_addr0", 32'(log_addr[base + 3]), 32'h20000);
        chk("mf_addr1", 32'(log_addr[base + 4]), 32'h20001);
        chk("mf_head", data_out, 32'h20000);
        pop = 1'b1;
        step();
        pop = 1'b0;
        chk("mf_head2", data_out, 32'h20001);
        pop = 1'b1;
        step();
        pop = 1'b0;
        chk("mf_empty", 32'(data_valid), 32'd0);

        // Asynchronous reset during a burst
        start_addr  = 18'h01000;
        frame_words = 18'd20;
        pulse_fs();
        run(4);
        chk("pre_rst_valid", 32'(data_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_addr", 32'(mem_addr), 32'd0);
        chk("arst_dout", data_out, 32'd0);
        chk("arst_valid", 32'(data_valid), 32'd0);
        run(2);
        reset = 1'b0;
        base = log_addr.size();
        run(10);
        chk("post_rst_noreq", log_addr.size() - base, 0);
        chk("post_rst_req", 32'(mem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
